// File: rtl/md_result_queue.sv
// In-order result buffer between the mul/div unit and the common data bus.
// Holds completed results, requests the CDB, and broadcasts the head entry on grant.
module md_result_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    input  logic signed [31:0]         i_result,
    input  logic [5:0]                 i_rrn,
    input  logic [4:0]                 i_arn,
    output logic                       o_ready,
    input  logic                       i_flush,
    output logic                       o_get_bus,
    input  logic                       i_bus_granted,
    output logic                       o_cdb_valid,
    output logic signed [31:0]         o_cdb_result,
    output logic [5:0]                 o_cdb_rrn,
    output logic [4:0]                 o_cdb_arn,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Entry storage carries no reset; only pointers and count define validity.
    logic signed [31:0] mem_result [DEPTH];
    logic [5:0]         mem_rrn    [DEPTH];
    logic [4:0]         mem_arn    [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic full;
    logic empty;
    logic get_bus;
    logic push;
    logic pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign get_bus = !empty && !i_flush;
    assign pop     = get_bus && i_bus_granted;
    // Acceptance is gated on the registered count, so a same-cycle pop never frees a slot.
    assign push    = i_valid && !full && !i_flush;

    assign o_ready     = !full;
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_count     = count;
    assign o_get_bus   = get_bus;
    assign o_cdb_valid = pop;

    always_comb begin
        o_cdb_result = '0;
        o_cdb_rrn    = '0;
        o_cdb_arn    = '0;
        if (pop) begin
            o_cdb_result = mem_result[rd_ptr];
            o_cdb_rrn    = mem_rrn[rd_ptr];
            o_cdb_arn    = mem_arn[rd_ptr];
        end
    end

    // Control state: pointers and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Data path: entry write at the write pointer
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_result[wr_ptr] <= i_result;
            mem_rrn[wr_ptr]    <= i_rrn;
            mem_arn[wr_ptr]    <= i_arn;
        end
    end

endmodule

// File: doc/md_result_queue.md
# md_result_queue

Result buffer sitting directly downstream of the multiply/divide execution unit and upstream of the common data bus (CDB). It accepts completed results (value, renamed register number, architectural register number) from the mul/div unit, holds them in a small in-order FIFO, requests the CDB from the bus arbiter, and drives the head entry onto the bus when granted. This decouples mul/div completion from CDB arbitration so the reservation station can keep issuing while the bus is contested.

## Interface

Parameters:
- DEPTH, 4, number of result entries; power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  upstream result valid.
- i_result  in  32  mul/div result value.
- i_rrn  in  6  renamed destination register.
- i_arn  in  5  architectural destination register.
- o_ready  out  1  queue can accept a result this cycle.
- i_flush  in  1  synchronous discard of all held entries (misprediction).
- o_get_bus  out  1  CDB request to arbiter.
- i_bus_granted  in  1  arbiter grant for this cycle.
- o_cdb_valid  out  1  CDB payload valid this cycle.
- o_cdb_result  out  32  CDB result value.
- o_cdb_rrn  out  6  CDB renamed register.
- o_cdb_arn  out  5  CDB architectural register.
- o_count  out  $clog2(DEPTH)+1  occupied entries.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.

## Operation

- Storage: circular buffer of DEPTH entries {result, rrn, arn}; write pointer, read pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), registered count.
- Push: i_valid & o_ready at rising edge → entry written at write pointer, write pointer +1.
- o_ready = !o_full (combinational from registered count). No push accepted when full, even if a pop occurs the same cycle.
- o_get_bus = !o_empty & !i_flush.
- Pop: o_get_bus & i_bus_granted in a cycle → o_cdb_valid = 1, o_cdb_* = head entry during that cycle; read pointer +1 at the edge.
- o_cdb_valid = o_get_bus & i_bus_granted; when 0, o_cdb_result/rrn/arn driven to 0.
- Grant while not requesting: ignored, no state change.
- Simultaneous push and pop: both take effect, count unchanged.
- Order strictly FIFO; entries leave in the order accepted.
- Flush: at the edge with i_flush = 1, count, read and write pointers → 0; flush has priority over push and pop in the same cycle (nothing accepted, nothing counted as popped; o_cdb_valid forced 0 that cycle).
- No bypass: a result pushed into an empty queue is not visible on the CDB in its push cycle.
- Reset (asynchronous, any time, including mid-transfer): pointers and count → 0; entry storage contents don't-care.

## Timing

- Reset values: o_ready = 1, o_get_bus = 0, o_cdb_valid = 0, o_cdb_result/rrn/arn = 0, o_count = 0, o_full = 0, o_empty = 1.
- Latency: push accepted at edge N → o_get_bus high in cycle N+1; earliest CDB broadcast in cycle N+1 if granted.
- Sustained throughput: one push and one pop per cycle under continuous grant.
- o_get_bus, o_ready, o_full, o_empty, o_count depend only on registered state (plus i_flush for o_get_bus); o_cdb_valid is combinational from i_bus_granted.
- Arbiter may hold grant low indefinitely; head entry and o_get_bus stay stable until granted or flushed.

## Test plan

- Reset then single push {0xDEADBEEF, rrn 5, arn 3}, grant held high → o_get_bus = 1 next cycle, o_cdb_valid = 1 with those values same cycle, o_empty = 1 after.
- Push 4 entries with grant low → o_full = 1, o_ready = 0, o_count = 4; a 5th i_valid is not accepted; then grant 4 cycles → results emerge in push order, o_empty = 1.
- Queue holding 2 entries, push and grant every cycle for 10 cycles → o_count stays 2, pointers wrap, CDB sequence matches push sequence exactly.
- Queue holding 3 entries, i_flush with simultaneous i_valid and grant → o_cdb_valid = 0 that cycle, next cycle o_count = 0, o_get_bus = 0, pushed entry absent.
- Grant asserted while empty → o_cdb_valid = 0, o_cdb_result = 0, o_count unchanged.
- Assert i_rst_n low mid-cycle while full and granted → outputs return to reset values immediately (asynchronously), before the next clock edge.
